// File: rtl/ec_datapath.sv
// Accumulator datapath: PC, IR, accumulator A and a 32x8 unified memory for an 8-bit CU.
// Defining EC_DATAPATH_OVF_EN adds the Ovf signed-overflow flag output.

module ec_datapath_word #(
  parameter int DW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          core_we,
  input  logic          prog_we,
  input  logic [DW-1:0] core_data,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] q
);
  // Program-load port has priority over a core store to the same word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)       q <= '0;
    else if (prog_we) q <= prog_data;
    else if (core_we) q <= core_data;
  end
endmodule

module ec_datapath #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic          Halt,
  input  logic [DW-1:0] Input,
  input  logic          ProgWe,
  input  logic [AW-1:0] ProgAddr,
  input  logic [DW-1:0] ProgData,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] Output,
  output logic [AW-1:0] PCout
`ifdef EC_DATAPATH_OVF_EN
  ,
  output logic          Ovf
`endif
);
  localparam int DEPTH = 2**AW;

  logic [AW-1:0]             pc;
  logic [DW-1:0]             ir_reg;
  logic [DW-1:0]             a_reg;
  logic [DEPTH-1:0][DW-1:0]  mem;
  logic [AW-1:0]             addr;
  logic [DW-1:0]             rdata;
  logic [DW-1:0]             alu;
  logic [DW-1:0]             a_next;

  assign addr  = Meminst ? ir_reg[AW-1:0] : pc;
  assign rdata = mem[addr];
  // Subtract as A + ~M + 1; result wraps modulo 2**DW.
  assign alu   = a_reg + (Sub ? ~rdata : rdata) + DW'(Sub);

  always_comb begin
    a_next = alu;
    unique case (Asel)
      2'b00:   a_next = alu;
      2'b01:   a_next = Input;
      2'b10:   a_next = rdata;
      default: a_next = '0;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    ec_datapath_word #(.DW(DW)) u_word (
      .Clock     (Clock),
      .Reset     (Reset),
      .core_we   (!Halt && MemWr && (addr == AW'(g))),
      .prog_we   (ProgWe && (ProgAddr == AW'(g))),
      .core_data (a_reg),
      .prog_data (ProgData),
      .q         (mem[g])
    );
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc     <= '0;
      ir_reg <= '0;
      a_reg  <= '0;
    end else if (!Halt) begin
      if (IRload) ir_reg <= rdata;
      if (PCload) pc     <= JMPmux ? ir_reg[AW-1:0] : pc + AW'(1);
      if (Aload)  a_reg  <= a_next;
    end
  end

  assign IR     = ir_reg[DW-1:DW-3];
  assign Aeq0   = (a_reg == '0);
  assign Apos   = !a_reg[DW-1] && (a_reg != '0);
  assign Output = a_reg;
  assign PCout  = pc;

`ifdef EC_DATAPATH_OVF_EN
  logic op_sign;
  logic ovf_now;

  // Effective operand sign is that of ~M when subtracting.
  assign op_sign = Sub ? ~rdata[DW-1] : rdata[DW-1];
  assign ovf_now = (a_reg[DW-1] == op_sign) && (alu[DW-1] != a_reg[DW-1]);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)               Ovf <= 1'b0;
    else if (!Halt && Aload)  Ovf <= (Asel == 2'b00) && ovf_now;
  end
`endif
endmodule

// File: tb/tb_ec_datapath.sv
// Scoreboard bench for ec_datapath: an integer-arithmetic model predicts the full
// architectural state after each edge; a monitor pops and compares it.
module tb_ec_datapath;
  localparam int DW = 8, AW = 5, DEPTH = 32;

  logic          Clock = 1'b0, Reset = 1'b0;
  logic          IRload = 0, JMPmux = 0, PCload = 0, Meminst = 0, MemWr = 0;
  logic [1:0]    Asel = '0;
  logic          Aload = 0, Sub = 0, Halt = 0, ProgWe = 0;
  logic [DW-1:0] Input = '0, ProgData = '0;
  logic [AW-1:0] ProgAddr = '0;
  logic [2:0]    IR;
  logic          Aeq0, Apos;
  logic [DW-1:0] Output;
  logic [AW-1:0] PCout;
`ifdef EC_DATAPATH_OVF_EN
  logic          Ovf;
`endif

  ec_datapath #(.DW(DW), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt),
    .Input(Input), .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(Output), .PCout(PCout)
`ifdef EC_DATAPATH_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic irload, jmp, pcload, meminst, memwr;
    logic [1:0] asel;
    logic aload, sub, halt;
    logic [DW-1:0] inp;
    logic pwe;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
  } ctl_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] a;
    logic          ovf;
    logic [DEPTH-1:0][DW-1:0] mem;
  } snap_t;

  snap_t q[$];
  int total = 0, bad = 0;

  int   m_pc, m_ir, m_a;
  logic m_ovf;
  int   m_mem[DEPTH];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_a = 0; m_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
  endtask

  // Reference: plain integer arithmetic on the architectural state.
  task automatic model_step(input ctl_t c);
    int addr, rd, oa, oir, sa, sm, sr;
    addr = c.meminst ? (m_ir % 32) : m_pc;
    rd = m_mem[addr]; oa = m_a; oir = m_ir;
    if (!c.halt) begin
      if (c.irload) m_ir = rd;
      if (c.pcload) m_pc = c.jmp ? (oir % 32) : ((m_pc + 1) % 32);
      if (c.memwr)  m_mem[addr] = oa;
      if (c.aload) begin
        m_ovf = 1'b0;
        case (int'(c.asel))
          0: begin
            sa = (oa > 127) ? oa - 256 : oa;
            sm = (rd > 127) ? rd - 256 : rd;
            sr = c.sub ? sa - sm : sa + sm;
            m_ovf = (sr > 127) || (sr < -128);
            m_a = (sr + 256) % 256;
          end
          1: m_a = int'(c.inp);
          2: m_a = rd;
          default: m_a = 0;
        endcase
      end
    end
    if (c.pwe) m_mem[c.paddr] = int'(c.pdata);
  endtask

  task automatic push_exp();
    snap_t s;
    s.pc = AW'(m_pc); s.ir = DW'(m_ir); s.a = DW'(m_a); s.ovf = m_ovf;
    for (int i = 0; i < DEPTH; i++) s.mem[i] = DW'(m_mem[i]);
    q.push_back(s);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input ctl_t c);
    IRload = c.irload; JMPmux = c.jmp; PCload = c.pcload; Meminst = c.meminst;
    MemWr = c.memwr; Asel = c.asel; Aload = c.aload; Sub = c.sub; Halt = c.halt;
    Input = c.inp; ProgWe = c.pwe; ProgAddr = c.paddr; ProgData = c.pdata;
    model_step(c);
    push_exp();
    @(negedge Clock);
  endtask

  function automatic ctl_t rnd_ctl();
    ctl_t c;
    c.irload = 1'($urandom_range(1)); c.jmp = 1'($urandom_range(1));
    c.pcload = 1'($urandom_range(1)); c.meminst = 1'($urandom_range(1));
    c.memwr = 1'($urandom_range(1)); c.asel = 2'($urandom_range(3));
    c.aload = 1'($urandom_range(1)); c.sub = 1'($urandom_range(1));
    c.halt = ($urandom_range(7) == 0); c.inp = DW'($urandom_range(255));
    c.pwe = ($urandom_range(3) == 0); c.paddr = AW'($urandom_range(31));
    c.pdata = DW'($urandom_range(255));
    return c;
  endfunction

  // Monitor: after each rising edge, compare DUT state to the oldest prediction.
  initial begin
    snap_t e;
    forever begin
      @(posedge Clock); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", PCout, e.pc);
        check("ir", IR, e.ir[7:5]);
        check("acc", Output, e.a);
        check("aeq0", Aeq0, e.a == 0);
        check("apos", Apos, (e.a != 0) && (e.a < 128));
`ifdef EC_DATAPATH_OVF_EN
        check("ovf", Ovf, e.ovf);
`endif
        check("mem", dut.mem, e.mem);
      end
    end
  end

  initial begin
    ctl_t c;
    model_reset();
    #1;
    check("rst_pc", PCout, 0); check("rst_ir", IR, 0); check("rst_acc", Output, 0);
    check("rst_aeq0", Aeq0, 1); check("rst_apos", Apos, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    // Fetch wrap 31 -> 0
    c = '0; c.pwe = 1; c.paddr = 0;  c.pdata = 8'hFF; drive(c);
    c = '0; c.pwe = 1; c.paddr = 31; c.pdata = 8'hA3; drive(c);
    c = '0; c.irload = 1; c.pcload = 1; drive(c);
    c = '0; c.pcload = 1; c.jmp = 1; drive(c);
    check("jump_to_31", PCout, 31);
    c = '0; c.irload = 1; c.pcload = 1; drive(c);
    check("wrap_ir", IR, 3'b101); check("wrap_pc", PCout, 0);

    // ALU sub/add through IR-addressed operand mem[20]
    c = '0; c.pwe = 1; c.paddr = 0; c.pdata = 8'h14; drive(c);
    c = '0; c.pwe = 1; c.paddr = 20; c.pdata = 8'h07; c.aload = 1; c.asel = 2'b01; c.inp = 8'h05; drive(c);
    c = '0; c.irload = 1; drive(c);
    c = '0; c.meminst = 1; c.aload = 1; c.asel = 2'b00; c.sub = 1; drive(c);
    check("sub_acc", Output, 8'hFE); check("sub_apos", Apos, 0); check("sub_aeq0", Aeq0, 0);
    c.sub = 0; drive(c);
    check("add_acc", Output, 8'h05); check("add_apos", Apos, 1);
    c = '0; c.aload = 1; c.asel = 2'b01; c.inp = 8'h7F; c.pwe = 1; c.paddr = 20; c.pdata = 8'h01; drive(c);
    c = '0; c.meminst = 1; c.aload = 1; c.asel = 2'b00; drive(c);
    check("ovf_acc", Output, 8'h80);
`ifdef EC_DATAPATH_OVF_EN
    check("ovf_flag", Ovf, 1);
`endif

    // Store old A while clearing A, then load it back
    c = '0; c.aload = 1; c.asel = 2'b01; c.inp = 8'h3C; drive(c);
    c = '0; c.meminst = 1; c.memwr = 1; c.aload = 1; c.asel = 2'b11; drive(c);
    check("store_mem20", dut.mem[20], 8'h3C); check("store_aeq0", Aeq0, 1);
    c = '0; c.meminst = 1; c.aload = 1; c.asel = 2'b10; drive(c);
    check("load_acc", Output, 8'h3C);

    // Jump to IR[4:0]=10, then halt with everything asserted
    c = '0; c.pwe = 1; c.paddr = 0; c.pdata = 8'hCA; drive(c);
    c = '0; c.irload = 1; drive(c);
    c = '0; c.pcload = 1; c.jmp = 1; drive(c);
    check("jmp_pc", PCout, 10); check("jmp_ir", IR, 3'b110);
    for (int k = 0; k < 3; k++) begin
      c = '1; c.asel = 2'(k); c.inp = 8'h99; c.pwe = (k == 0); c.paddr = 2; c.pdata = 8'h11;
      drive(c);
      check("halt_pc", PCout, 10); check("halt_acc", Output, 8'h3C); check("halt_ir", IR, 3'b110);
    end
    check("halt_progwe", dut.mem[2], 8'h11);

    // ProgWe and MemWr collide on address 4
    c = '0; c.pwe = 1; c.paddr = 10; c.pdata = 8'h04; drive(c);
    c = '0; c.irload = 1; c.aload = 1; c.asel = 2'b01; c.inp = 8'h55; drive(c);
    c = '0; c.meminst = 1; c.memwr = 1; c.pwe = 1; c.paddr = 4; c.pdata = 8'hAA; drive(c);
    check("collide_mem4", dut.mem[4], 8'hAA);

    repeat (400) drive(rnd_ctl());

    // Asynchronous reset in the middle of the low clock phase
    c = '0; c.pwe = 1; c.paddr = 7; c.pdata = 8'h5A; c.aload = 1; c.asel = 2'b01; c.inp = 8'h42; drive(c);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check("arst_pc", PCout, 0); check("arst_acc", Output, 0); check("arst_aeq0", Aeq0, 1);
    check("arst_apos", Apos, 0); check("arst_mem7", dut.mem[7], 0);
    @(negedge Clock);
    Reset = 1'b1;

    repeat (150) drive(rnd_ctl());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ec_datapath.md
Name: ec_datapath

Overview:
- 8-bit accumulator datapath driven by the CU control word: IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt.
- Returns the CU's inputs: opcode IR[7:5] and status flags Aeq0/Apos.
- Holds the PC, IR, accumulator A and a 32x8 unified program/data memory.
- A program-load port fills memory before execution.

Parameters:
- DW, 8, data/accumulator/IR width.
- AW, 5, address width; memory depth is 2**AW = 32.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IRload  input  1  load IR from memory read data.
- JMPmux  input  1  PC next-value select: 0 = PC+1, 1 = IR[4:0].
- PCload  input  1  load PC with the selected next value.
- Meminst  input  1  memory address select: 0 = PC, 1 = IR[4:0].
- MemWr  input  1  write A into memory at the selected address.
- Asel  input  2  A source: 00 = ALU, 01 = Input, 10 = memory read data, 11 = 8'h00.
- Aload  input  1  load A from the Asel source.
- Sub  input  1  ALU op: 0 = A+M, 1 = A-M.
- Halt  input  1  freeze all architectural state.
- Input  input  DW  external data input.
- ProgWe  input  1  program-load write strobe.
- ProgAddr  input  AW  program-load address.
- ProgData  input  DW  program-load data.
- IR  output  3  IR[7:5] opcode to the CU.
- Aeq0  output  1  A == 0.
- Apos  output  1  A strictly positive: A[7]==0 and A!=0.
- Output  output  DW  current A value.
- PCout  output  AW  current PC, for debug.

Behaviour:
- Reset low, asynchronous:
  - PC=0, IRreg=8'h00, A=8'h00, all 32 memory words = 8'h00.
  - Outputs therefore reset to IR=3'b000, Aeq0=1, Apos=0, Output=0, PCout=0.
  - Release is synchronous to the next rising edge.
- Memory address: Meminst ? IRreg[4:0] : PC.
- Memory read is combinational (zero latency); memory write is synchronous.
- ALU: 8-bit two's complement, result modulo 256, no carry out; Sub=1 computes A + ~M + 1.
- Rising-edge updates (when Halt=0):
  - IRload: IRreg <= mem[addr].
  - PCload: PC <= JMPmux ? IRreg[4:0] : PC+1. PC+1 wraps 31 -> 0.
  - Aload: A <= Asel source.
  - MemWr: mem[addr] <= A, using the pre-edge A.
- Simultaneous events:
  - All controls sample pre-edge values. A fetch cycle (IRload=1, PCload=1, JMPmux=0) gives IR <= mem[PC_old] and PC <= PC_old+1.
  - JMPmux with IRload in the same cycle uses the old IRreg.
  - Aload with MemWr writes the old A to memory and loads the new A.
  - A read from the address being written returns the old data in that cycle.
- Halt=1:
  - PC, IRreg, A and memory hold, regardless of other controls.
  - ProgWe still writes.
  - Outputs stay valid.
- ProgWe:
  - mem[ProgAddr] <= ProgData; honoured even when Halt=1.
  - Same cycle as MemWr to the same address: ProgWe wins. Different addresses: both writes occur.
- Aeq0, Apos, Output, IR and PCout are combinational from registers, with no glitch-dependent behaviour required.
- Reset asserted mid-instruction: immediate return to the reset state, including the memory clear. Any program must be reloaded.
- Undefined Asel values do not exist; all four encodings are defined.

Optional Feature:
- Macro: EC_DATAPATH_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit), a register reset to 0.
  - On every Aload with Asel=00, Ovf <= signed overflow of that add/sub: operand signs equal (add) or differ (sub) and the result sign differs from A's sign.
  - Any other Aload clears Ovf.
  - Ovf holds while Halt=1.
- Undefined: no Ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- Reset: load garbage into registers, pulse Reset low mid-cycle -> PC=0, A=0, Aeq0=1, Apos=0, mem[7]=0 immediately, without waiting for a clock.
- Fetch wrap: ProgWe mem[31]=8'hA3, force PC to 31, IRload=PCload=1, JMPmux=0 -> IR=3'b101, PC=0 next cycle.
- ALU:
  - A=8'h05, mem[IR[4:0]]=8'h07, Meminst=1, Asel=00, Sub=1, Aload=1 -> A=8'hFE, Apos=0, Aeq0=0.
  - Then Sub=0 with the same operand -> A=8'h05, Apos=1.
  - With EC_DATAPATH_OVF_EN: A=8'h7F plus M=8'h01 -> A=8'h80, Ovf=1.
- Store/load: A=8'h3C, Meminst=1, IR[4:0]=5'd20, MemWr=1 -> mem[20]=8'h3C. Next cycle Asel=10, Aload=1 -> A=8'h3C.
- Jump and Halt:
  - IRreg=8'b110_01010, PCload=1, JMPmux=1 -> PC=10.
  - With Halt=1 and all controls asserted for 3 cycles -> PC, A and IR unchanged, while ProgWe still writes mem[2]=8'h11.
- Write collision: ProgWe and MemWr to address 4 in the same cycle, ProgData=8'hAA, A=8'h55 -> mem[4]=8'hAA.
